bitfield_pipe: RTL
==================

Name: bitfield_pipe

Overview:
- Pipelined, parametrised bitfield execution unit; successor to the combinational bitfield unit in the integer ALU path.
- Takes pre-decoded operands, not raw instruction bits.
- Adds a valid/ready handshake, stall and flush, a tag pass-through, and two new ops: population count and field bit-reverse.
- Sits between issue/operand-read and the result bus as a 2-stage functional unit.

Parameters:
WID, 80, datapath width in bits (min 16)
OW, $clog2(WID), width of offset/width-minus-one fields
TAGW, 6, width of the opaque tag carried with each operation

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  synchronous kill of all in-flight ops
valid_i  input  1  operation presented
ready_o  output  1  unit can accept this cycle
op_i  input  4  0 SET, 1 CLR, 2 CHG, 3 INS, 5 EXT, 6 EXTU, 8 FFO, 9 POPC, 10 REV; others reserved
src_i  input  WID  insert value (INS)
dst_i  input  WID  target/source word
off_i  input  OW  field offset (lsb position)
wm1_i  input  OW  field width minus one
tag_i  input  TAGW  opaque tag
valid_o  output  1  result valid
ready_i  input  1  consumer accepts result
res_o  output  WID  result
mask_o  output  WID  field mask used for the result
tag_o  output  TAGW  tag of the result

Behaviour:
- Reset (rst_ni low, async): s1/s2 valid cleared; valid_o=0, res_o=0, mask_o=0, tag_o=0. ready_o=1 on the first cycle after release.
- Stage 1 (S1) registers op, src, dst, off, wm1, tag and mask on accept (valid_i & ready_o).
- Stage 2 (S2) registers the computed result, mask and tag. Latency: accept at cycle N gives valid_o at N+2 with no stall.
- Advance rules:
  - S2 loads when S1 is valid and (S2 empty or ready_i).
  - ready_o = !S1.valid | S2-load.
  - Full throughput is 1 op/cycle.
  - Holding ready_i low freezes S2 outputs stable. S1 then holds, and ready_o drops once both stages are full.
- Mask: bit n set iff off <= n <= off+wm1, computed in OW+1 bits. A field extending past WID-1 is truncated at WID-1; it does not wrap.
- Ops (F = dst & mask, L = wm1+1 clipped to WID-off):
  - SET/CLR/CHG: set/clear/invert masked bits of dst.
  - INS: (src<<off) under mask, dst elsewhere.
  - EXTU: F>>off, zero-filled.
  - EXT: F>>off, then sign-extended from bit L-1.
  - FFO: index, relative to off, of the most significant set bit of F. Returns all-ones (WID bits) if F==0.
  - POPC: count of set bits in F, zero-extended.
  - REV: the L field bits reversed in place; dst unchanged outside the mask.
  - Reserved op: res_o=0, mask_o=0, valid_o still asserted, tag passed through.
- flush_i: next edge clears S1/S2 valid. An op presented with flush_i is not accepted; ready_o stays as computed. Flush overrides ready_i.
- Simultaneous accept and S1 drain into S2 in the same cycle is legal and loses nothing.
- Reset mid-operation discards all in-flight ops. No output is produced for them.
- Outputs are driven only from S2 registers (no combinational path input->output except ready_o from ready_i).

Test Plan:
- WID=80, SET off=4 wm1=7, dst=0 -> after 2 cycles res_o=0xFF0, mask_o=0xFF0, tag echoed.
- EXT off=8 wm1=3, dst=0xA00 -> res_o all-ones except low 4 = 0xA (i.e. -6). EXTU, same operands -> 0xA.
- Boundary: INS off=76 wm1=7, src=0xFF, dst=0 -> mask bits 76..79 only; res_o=0xF<<76.
- FFO off=0 wm1=79, dst=0 -> res_o all-ones. dst=1<<37 -> 37. POPC dst=0xF0F0 off=4 wm1=7 -> 4. REV off=0 wm1=3 dst=0x1 -> 0x8.
- Back-to-back 8 ops with ready_i low for cycles 3-6 -> no loss/duplication, order and tags preserved, ready_o low while both stages are full, res_o stable while stalled.
- flush_i with 2 ops in flight -> valid_o low next cycle, neither op emerges. Assert rst_ni mid-stream -> outputs 0 immediately (async).

Source files
------------

// File: rtl/bitfield_pipe.sv
// Two-stage pipelined bitfield unit: S1 latches operands and field mask, S2 latches the result.
// Valid/ready handshake with stall back-pressure, synchronous flush and tag pass-through.
module bitfield_pipe #(
    parameter int unsigned WID  = 80,
    parameter int unsigned OW   = $clog2(WID),
    parameter int unsigned TAGW = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      op_i,
    input  logic [WID-1:0]  src_i,
    input  logic [WID-1:0]  dst_i,
    input  logic [OW-1:0]   off_i,
    input  logic [OW-1:0]   wm1_i,
    input  logic [TAGW-1:0] tag_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [WID-1:0]  res_o,
    output logic [WID-1:0]  mask_o,
    output logic [TAGW-1:0] tag_o
);

    localparam logic [3:0] OpSet  = 4'd0;
    localparam logic [3:0] OpClr  = 4'd1;
    localparam logic [3:0] OpChg  = 4'd2;
    localparam logic [3:0] OpIns  = 4'd3;
    localparam logic [3:0] OpExt  = 4'd5;
    localparam logic [3:0] OpExtu = 4'd6;
    localparam logic [3:0] OpFfo  = 4'd8;
    localparam logic [3:0] OpPopc = 4'd9;
    localparam logic [3:0] OpRev  = 4'd10;

    localparam logic [OW:0] WidW = WID[OW:0];
    localparam logic [OW:0] OneW = {{OW{1'b0}}, 1'b1};

    typedef struct packed {
        logic [3:0]      op;
        logic [WID-1:0]  src;
        logic [WID-1:0]  dst;
        logic [WID-1:0]  mask;
        logic [OW-1:0]   off;
        logic [OW-1:0]   wm1;
        logic [TAGW-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [WID-1:0]  res;
        logic [WID-1:0]  mask;
        logic [TAGW-1:0] tag;
    } s2_t;

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic s1_valid_d, s1_valid_q;
    logic s2_valid_d, s2_valid_q;
    logic s2_load, accept;

    // ---------------- Handshake and stage control ----------------
    assign s2_load = s1_valid_q & (~s2_valid_q | ready_i);
    assign ready_o = ~s1_valid_q | s2_load;
    assign accept  = valid_i & ready_o & ~flush_i;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (s2_load) begin
                s1_valid_d = 1'b0;
            end
            if (s2_load) begin
                s2_valid_d = 1'b1;
            end else if (ready_i) begin
                s2_valid_d = 1'b0;
            end
        end
    end

    // ---------------- Stage 1: field mask and operand capture ----------------
    logic [WID-1:0] mask_in;
    logic [OW:0]    lo_w, hi_w;

    always_comb begin
        // Upper bound in OW+1 bits so an overlong field clips at WID-1 instead of wrapping.
        lo_w = {1'b0, off_i};
        hi_w = lo_w + {1'b0, wm1_i};
        for (int n = 0; n < WID; n++) begin
            mask_in[n] = (lo_w <= n[OW:0]) && (n[OW:0] <= hi_w);
        end
    end

    always_comb begin
        s1_d = s1_q;
        if (accept) begin
            s1_d.op   = op_i;
            s1_d.src  = src_i;
            s1_d.dst  = dst_i;
            s1_d.mask = mask_in;
            s1_d.off  = off_i;
            s1_d.wm1  = wm1_i;
            s1_d.tag  = tag_i;
        end
    end

    // ---------------- Stage 2: operation datapath ----------------
    logic [WID-1:0] fld, fld_lo, lo_mask, top_bit, rev_all, rev_fld, ffo_idx, pop_cnt;
    logic [WID-1:0] res_c, mask_c;
    logic [OW:0]    room, wlen, len, shamt;
    logic           sign;

    always_comb begin
        fld    = s1_q.dst & s1_q.mask;
        fld_lo = fld >> s1_q.off;
        room   = ({1'b0, s1_q.off} < WidW) ? (WidW - {1'b0, s1_q.off}) : '0;
        wlen   = {1'b0, s1_q.wm1} + OneW;
        len    = (wlen < room) ? wlen : room;
        shamt  = WidW - len;

        // lo_mask has the low L bits set; top_bit isolates bit L-1 (sign of the field).
        lo_mask = {WID{1'b1}} >> shamt;
        top_bit = lo_mask & ~(lo_mask >> 1);
        sign    = |(fld_lo & top_bit);

        for (int i = 0; i < WID; i++) begin
            rev_all[WID-1-i] = fld_lo[i];
        end
        rev_fld = rev_all >> shamt;

        ffo_idx = '1;
        pop_cnt = '0;
        for (int i = 0; i < WID; i++) begin
            if (fld[i]) begin
                ffo_idx = WID'(i) - WID'(s1_q.off);
            end
            pop_cnt = pop_cnt + WID'(fld[i]);
        end
    end

    always_comb begin
        res_c  = '0;
        mask_c = s1_q.mask;
        case (s1_q.op)
            OpSet:   res_c = s1_q.dst | s1_q.mask;
            OpClr:   res_c = s1_q.dst & ~s1_q.mask;
            OpChg:   res_c = s1_q.dst ^ s1_q.mask;
            OpIns:   res_c = ((s1_q.src << s1_q.off) & s1_q.mask) | (s1_q.dst & ~s1_q.mask);
            OpExt:   res_c = fld_lo | (sign ? ~lo_mask : '0);
            OpExtu:  res_c = fld_lo;
            OpFfo:   res_c = ffo_idx;
            OpPopc:  res_c = pop_cnt;
            OpRev:   res_c = (s1_q.dst & ~s1_q.mask) | ((rev_fld << s1_q.off) & s1_q.mask);
            default: begin
                res_c  = '0;
                mask_c = '0;
            end
        endcase
    end

    always_comb begin
        s2_d = s2_q;
        if (s2_load) begin
            s2_d.res  = res_c;
            s2_d.mask = mask_c;
            s2_d.tag  = s1_q.tag;
        end
    end

    // ---------------- State ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign valid_o = s2_valid_q;
    assign res_o   = s2_q.res;
    assign mask_o  = s2_q.mask;
    assign tag_o   = s2_q.tag;

endmodule
